// File: rtl/store_buffer.sv
// Word-store FIFO between EX/MEM and data memory.
// Drains in load-free cycles; loads forward from the youngest matching entry.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   st_valid,
    input  logic [31:0]            st_addr,
    input  logic [31:0]            st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [31:0]            ld_addr,
    output logic [31:0]            ld_data,
    output logic                   ld_hit,
    input  logic [31:0]            mem_rdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [29:0]   ent_addr [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;
    logic          hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] fwd_idx;
    logic          unused_st_lo;

    assign unused_st_lo = ^st_addr[1:0];

    assign count    = cnt;
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign st_ready = !full;
    assign push     = st_valid && !full;
    assign pop      = !empty && !ld_valid;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PW'(k);
            if ((CW'(k) < cnt) && (ent_addr[fwd_idx] == ld_addr[31:2])) begin
                hit      = 1'b1;
                fwd_data = ent_data[fwd_idx];
            end
        end
    end

    always_comb begin
        mem_read  = ld_valid;
        mem_write = pop;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_valid) begin
            mem_addr = ld_addr;
        end else if (pop) begin
            mem_addr  = {ent_addr[head], 2'b00};
            mem_wdata = ent_data[head];
        end
        ld_hit  = ld_valid && hit;
        ld_data = '0;
        if (ld_valid) begin
            ld_data = hit ? fwd_data : mem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (push) begin
                ent_addr[tail] <= st_addr[31:2];
                ent_data[tail] <= st_data;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Word-store buffer between the EX/MEM pipeline register and the data memory. It queues full-word stores, so store bursts do not compete with loads for the single memory address port. It drains queued stores into memory in cycles with no load. Loads that hit a queued store get the youngest matching data forwarded, bypassing stale memory contents.

## Interface
- DEPTH, 4, number of buffered stores; power of two, 2..16
- clock  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- st_valid  input  1  store request from EX/MEM (MemWrite of that stage)
- st_addr  input  32  store byte address; only bits [31:2] are significant
- st_data  input  32  store data (readreg2 value)
- st_ready  output  1  buffer can accept a store this cycle; equals !full
- ld_valid  input  1  load request from EX/MEM (MemRead of that stage)
- ld_addr  input  32  load byte address
- ld_data  output  32  load result to MEM/WB
- ld_hit  output  1  load was satisfied from the buffer
- mem_rdata  input  32  read data returned by the data memory
- mem_read  output  1  MemRead to data memory
- mem_write  output  1  MemWrite to data memory
- mem_addr  output  32  DAddress to data memory
- mem_wdata  output  32  Data_in to data memory
- count  output  $clog2(DEPTH)+1  occupied entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH

## Operation
- Storage: circular FIFO of DEPTH entries.
  - Each entry holds {word address [31:2], data}.
  - Registers are the head pointer (oldest entry), the tail pointer, and count.
- Push:
  - A push occurs on a rising edge when st_valid && st_ready.
  - The entry is written at the tail, and tail advances modulo DEPTH.
  - If st_valid && !st_ready, the store is not taken. The pipeline must stall on st_ready=0 and hold st_*.
- Drain (pop):
  - drain = !empty && !ld_valid.
  - While drain is asserted: mem_write=1, mem_addr={head addr,2'b00}, mem_wdata=head data.
  - Memory writes on the falling edge inside the cycle; head advances on the next rising edge.
- Load port:
  - When ld_valid=1: mem_read=1, mem_addr=ld_addr, mem_write=0.
  - When there is no load and no drain, mem_addr=0 and mem_wdata=0.
- Forwarding:
  - The buffer compares ld_addr[31:2] against every occupied entry.
  - ld_hit=1 when any occupied entry matches.
  - On a hit, ld_data is the data of the youngest matching entry, i.e. closest to tail in push order.
  - On a miss, ld_data=mem_rdata. When ld_valid=0, ld_data=0 and ld_hit=0.
- Same-cycle store and load:
  - The incoming st_data is not forwarded to a load in the same cycle, because program order places that load before that store.
  - Forwarding covers only entries already in the buffer.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full:
  - st_ready=0 while count==DEPTH, even if a pop occurs in the same cycle.
  - A push is never accepted into a full buffer.
- Count arithmetic: count_next = count + push − pop. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Starvation: continuous loads block draining. The buffer fills, and the store stall resolves once a load-free cycle occurs. This is required behaviour, not an error.
- Duplicate addresses: entries are not coalesced; both drain in order, and memory ends with the younger value.

## Timing
- Reset (reset_n=0, asynchronous):
  - head, tail and count are 0, and entry contents are cleared to 0.
  - Outputs: st_ready=1, empty=1, full=0, count=0, mem_write=0, mem_read=ld_valid, ld_hit=0.
- Reset mid-drain: queued stores are discarded; a partially completed negedge write is not the buffer's concern.
- Output paths:
  - st_ready, full, empty and count are functions of registered state only.
  - mem_* and ld_* are combinational from state, ld_valid and ld_addr.
- Latencies:
  - Push to earliest memory write: the push edge, then the next cycle with ld_valid=0.
  - A stored value is visible to forwarding from the cycle after its push edge.
  - Load latency is zero cycles: ld_data is valid in the same cycle as ld_valid.
- Drain rate: at most one entry per cycle.

## Test plan
- Reset then idle: assert reset_n=0 mid-cycle -> outputs immediately reach reset values; count=0, st_ready=1, mem_write=0.
- Fill and drain:
  - Stimulus: push 4 stores (addr 0x00,0x04,0x08,0x0C; data 1..4) with ld_valid held 1; expected full=1, st_ready=0, and a fifth st_valid is not taken.
  - Then drop ld_valid: mem_write=1 for 4 consecutive cycles with addr 0x00..0x0C in order, then empty=1.
- Forward youngest: push 0x10←0xAA then 0x10←0xBB while loading, then load 0x10 -> ld_hit=1, ld_data=0xBB; after drain, memory word 4 holds 0xBB.
- Miss: buffer holds 0x20; load 0x24 with mem_rdata=0x55 -> ld_hit=0, ld_data=0x55, mem_addr=0x24, mem_write=0.
- Byte-offset match: buffer holds 0x30←0x77; load 0x33 -> ld_hit=1, ld_data=0x77.
- Concurrency:
  - Stimulus: with count=2, push while draining; expected count stays 2 and the pointers wrap across index DEPTH-1 correctly.
  - Stimulus: assert reset_n=0 with count=3; expected count=0 and empty=1 without waiting for a clock edge.
